simd_mc_feeder: RTL

Memory-controller front end that sits directly upstream of simd_top_level. A host loads up to 64 operand pairs (A/B, 128 bits each) into an internal buffer, then issues one command (opcode plus last-index). The block then drives simd_top_level's valid_instruction, instruction and data_size, and streams mc_data_in_opa/opb at one beat per clock. It replaces hand-driven bench stimulus with a reusable, cycle-exact sequencer.

---
 rtl/simd_pkg.sv | 34 +++
 rtl/simd_operand_buf.sv | 41 ++++
 rtl/simd_mc_feeder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// Shared constants for the SIMD memory-controller feeder and its consumers.
package simd_pkg;

  // Datapath geometry
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned INSTR_W = 3;
  localparam int unsigned PAIR_W  = 2 * DATA_W;

  // Feeder sequencer states
  typedef logic [1:0] feeder_state_t;
  localparam feeder_state_t StIdle   = 2'd0;
  localparam feeder_state_t StIssue  = 2'd1;
  localparam feeder_state_t StStream = 2'd2;
  localparam feeder_state_t StDone   = 2'd3;

  // Opcode encodings understood by simd_top_level
  localparam logic [INSTR_W-1:0] OpAdd = 3'b000;
  localparam logic [INSTR_W-1:0] OpSub = 3'b001;
  localparam logic [INSTR_W-1:0] OpMul = 3'b010;
  localparam logic [INSTR_W-1:0] OpAnd = 3'b011;
  localparam logic [INSTR_W-1:0] OpOr  = 3'b100;
  localparam logic [INSTR_W-1:0] OpXor = 3'b101;
  localparam logic [INSTR_W-1:0] OpMin = 3'b110;
  localparam logic [INSTR_W-1:0] OpMax = 3'b111;

  // Buffer word layout: operand A in the upper half, operand B in the lower half
  function automatic logic [PAIR_W-1:0] pack_pair(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return {a, b};
  endfunction

endpackage

// File: rtl/simd_operand_buf.sv
// Operand-pair storage: one write port, one read port with a registered output.
// The array itself is never reset; only the read register is.
module simd_operand_buf
  import simd_pkg::*;
#(
  parameter int unsigned Depth = DEPTH,
  parameter int unsigned AddrW = ADDR_W,
  parameter int unsigned Width = PAIR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rd_data_q;

  // Storage write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; holds its value whenever no read is requested
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/simd_mc_feeder.sv
// Front end for simd_top_level: buffers operand pairs from a host, then replays
// them as a cycle-exact instruction + data stream on a single command.
module simd_mc_feeder
  import simd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data_a,
  input  logic [DATA_W-1:0]  wr_data_b,
  output logic               wr_err,
  input  logic               start,
  input  logic [INSTR_W-1:0] cmd_instruction,
  input  logic [ADDR_W-1:0]  cmd_size,
  output logic               busy,
  output logic               done,
  output logic               valid_instruction,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  data_size,
  output logic               valid_data,
  output logic [DATA_W-1:0]  mc_data_in_opa,
  output logic [DATA_W-1:0]  mc_data_in_opb
);

  feeder_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  beat_q, beat_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  size_q, size_d;
  logic               wr_err_q, wr_err_d;

  logic               idle;
  logic               last_beat;
  logic               buf_we;
  logic               buf_re;
  logic [ADDR_W-1:0]  buf_raddr;
  logic [PAIR_W-1:0]  buf_rdata;

  assign idle      = (state_q == StIdle);
  assign last_beat = (beat_q == size_q);
  // Host writes only land while idle, so a run always sees a stable buffer
  assign buf_we    = idle && wr_en;

  // Read scheduling: ISSUE fetches entry 0, each STREAM beat prefetches the
  // next entry. The last beat's prefetch (which wraps to 0 for a full-depth
  // run) is suppressed so the operands hold through DONE.
  always_comb begin
    buf_re    = 1'b0;
    buf_raddr = beat_q;
    unique case (state_q)
      StIssue: begin
        buf_re    = 1'b1;
        buf_raddr = beat_q;
      end
      StStream: begin
        buf_re    = !last_beat;
        buf_raddr = beat_q + ADDR_W'(1);
      end
      default: begin
        buf_re    = 1'b0;
        buf_raddr = beat_q;
      end
    endcase
  end

  simd_operand_buf #(
    .Depth (DEPTH),
    .AddrW (ADDR_W),
    .Width (PAIR_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_we),
    .wr_addr (wr_addr),
    .wr_data (pack_pair(wr_data_a, wr_data_b)),
    .rd_en   (buf_re),
    .rd_addr (buf_raddr),
    .rd_data (buf_rdata)
  );

  // Sequencer next state, beat counter and command latch
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    instr_d = instr_q;
    size_d  = size_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          beat_d  = '0;
          instr_d = cmd_instruction;
          size_d  = cmd_size;
        end
      end
      StIssue: begin
        state_d = StStream;
      end
      StStream: begin
        beat_d = beat_q + ADDR_W'(1);
        if (last_beat) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A write attempted while a run is in flight is dropped and flagged
  always_comb begin
    wr_err_d = wr_en && !idle;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      instr_q  <= '0;
      size_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      instr_q  <= instr_d;
      size_q   <= size_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Output decode
  always_comb begin
    busy              = !idle;
    done              = (state_q == StDone);
    valid_instruction = (state_q == StIssue) || (state_q == StStream);
    valid_data        = (state_q == StStream);
    instruction       = instr_q;
    data_size         = size_q;
    wr_err            = wr_err_q;
    mc_data_in_opa    = buf_rdata[PAIR_W-1:DATA_W];
    mc_data_in_opb    = buf_rdata[DATA_W-1:0];
  end

endmodule
